// File: rtl/ac_pkg.sv
// ac_pkg: state type, UPSTAT bit indices and CRF constants shared by the stream access controller
package ac_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT, ST_DONE} ac_state_t;
  localparam int UPSTAT_START = 0;
  localparam int UPSTAT_END = 1;
  localparam int ADDR_UPSTAT = 0;
  localparam int UPSTAT_DONE = 2;
endpackage

// File: rtl/frame_beat_counter.sv
// frame_beat_counter: raster position over W x H beats; in clk rst clr beat, out col row sof eol last
module frame_beat_counter
  import ac_pkg::*;
#(
  parameter int W = 4,
  parameter int H = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   beat,
  output logic [$clog2(W+1)-1:0] col,
  output logic [$clog2(H+1)-1:0] row,
  output logic                   sof,
  output logic                   eol,
  output logic                   last
);
  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(H + 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      col <= eol ? '0 : col + 1'b1;
      row <= eol ? row + 1'b1 : row;
    end
  end
  assign sof = col == '0 && row == '0;
  assign eol = col == CW'(W - 1);
  assign last = eol && row == RW'(H - 1);
endmodule

// File: rtl/stream_access_control.sv
// stream_access_control: gates DMA<->core AXI-Stream paths per job, marks frames/lines, reports UPSTAT=2 to the CRF; ports: s_axis/ac_up/up_ac/m_axis streams, crf_ac status in, ac_crf write/taps out
module stream_access_control
  import ac_pkg::*;
#(
  parameter int SRC_W          = 960,
  parameter int SRC_H          = 540,
  parameter int SCALE          = 4,
  parameter int PIX_WIDTH      = 24,
  parameter int CRF_DATA_WIDTH = 32,
  parameter int CRF_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [PIX_WIDTH-1:0]      s_axis_tdata,
  output logic                      ac_up_tvalid,
  input  logic                      up_ac_tready,
  output logic [PIX_WIDTH-1:0]      ac_up_tdata,
  output logic                      ac_up_tuser,
  output logic                      ac_up_tlast,
  input  logic                      up_ac_tvalid,
  output logic                      ac_up_tready,
  input  logic [PIX_WIDTH-1:0]      up_ac_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [PIX_WIDTH-1:0]      m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  input  logic                      crf_ac_UPSTART,
  input  logic                      crf_ac_UPEND,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      ac_crf_processing,
  output logic                      ac_crf_axisi_tvalid,
  output logic                      ac_crf_axisi_tready,
  output logic                      ac_crf_axiso_tvalid,
  output logic                      ac_crf_axiso_tready
);
  localparam int OUT_W = SRC_W * SCALE;
  localparam int OUT_H = SRC_H * SCALE;
  ac_state_t r_state, w_next;
  logic r_in_done;
  logic w_run, w_report, w_clr, w_in_beat, w_out_beat;
  logic w_in_sof, w_in_eol, w_in_last, w_out_sof, w_out_eol, w_out_last;
  logic [1:0] w_upstat;
  logic [$clog2(SRC_W+1)-1:0] w_in_col;
  logic [$clog2(SRC_H+1)-1:0] w_in_row;
  logic [$clog2(OUT_W+1)-1:0] w_out_col;
  logic [$clog2(OUT_H+1)-1:0] w_out_row;
  logic w_unused;
  assign w_upstat = {crf_ac_UPEND, crf_ac_UPSTART};
  assign w_run = r_state == ST_RUN && !rst;
  assign w_report = r_state == ST_REPORT && !rst;
  assign s_axis_tready = w_run && up_ac_tready && !r_in_done;
  assign ac_up_tvalid = w_run && s_axis_tvalid && !r_in_done;
  assign ac_up_tdata = s_axis_tdata;
  assign ac_up_tuser = w_run && w_in_sof;
  assign ac_up_tlast = w_run && w_in_eol;
  assign m_axis_tvalid = w_run && up_ac_tvalid;
  assign ac_up_tready = w_run && m_axis_tready;
  assign m_axis_tdata = up_ac_tdata;
  assign m_axis_tuser = w_run && w_out_sof;
  assign m_axis_tlast = w_run && w_out_eol;
  assign w_in_beat = s_axis_tvalid && s_axis_tready;
  assign w_out_beat = m_axis_tvalid && m_axis_tready;
  assign ac_crf_processing = w_run;
  assign ac_crf_wrt = w_report;
  assign ac_crf_waddr = CRF_ADDR_WIDTH'(ADDR_UPSTAT);
  assign ac_crf_wdata = w_report ? CRF_DATA_WIDTH'(UPSTAT_DONE) : '0;
  assign ac_crf_axisi_tvalid = s_axis_tvalid;
  assign ac_crf_axisi_tready = s_axis_tready;
  assign ac_crf_axiso_tvalid = m_axis_tvalid;
  assign ac_crf_axiso_tready = m_axis_tready;
  assign w_clr = w_next != ST_RUN;
  assign w_unused = ^{w_in_col, w_in_row, w_out_col, w_out_row};
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_upstat[UPSTAT_START] && !w_upstat[UPSTAT_END]) w_next = ST_RUN;
      ST_RUN:    if (!w_upstat[UPSTAT_START]) w_next = ST_IDLE;
                 else if (w_out_beat && w_out_last) w_next = ST_REPORT;
      ST_REPORT: if (!crf_ac_wbusy) w_next = ST_DONE;
      ST_DONE:   if (!w_upstat[UPSTAT_END]) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_in_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_in_done <= w_next == ST_RUN && (r_in_done || (w_in_beat && w_in_last));
    end
  end
  frame_beat_counter #(.W(SRC_W), .H(SRC_H)) u_in_cnt (
    .clk(clk), .rst(rst), .clr(w_clr), .beat(w_in_beat),
    .col(w_in_col), .row(w_in_row), .sof(w_in_sof), .eol(w_in_eol), .last(w_in_last)
  );
  frame_beat_counter #(.W(OUT_W), .H(OUT_H)) u_out_cnt (
    .clk(clk), .rst(rst), .clr(w_clr), .beat(w_out_beat),
    .col(w_out_col), .row(w_out_row), .sof(w_out_sof), .eol(w_out_eol), .last(w_out_last)
  );
endmodule

// File: tb/tb_stream_access_control.sv
// tb_stream_access_control: randomized streams checked each cycle against a beat-count reference model
module tb_stream_access_control;
  localparam int SW = 4, SH = 2, SC = 4, PW = 24;
  localparam int NIN = SW * SH, OW = SW * SC, NOUT = OW * SH * SC;
  logic clk = 0, rst;
  logic s_axis_tvalid, s_axis_tready, ac_up_tvalid, up_ac_tready, ac_up_tuser, ac_up_tlast;
  logic up_ac_tvalid, ac_up_tready, m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [PW-1:0] s_axis_tdata, ac_up_tdata, up_ac_tdata, m_axis_tdata;
  logic crf_ac_UPSTART, crf_ac_UPEND, crf_ac_wbusy, ac_crf_wrt, ac_crf_processing;
  logic [31:0] ac_crf_waddr, ac_crf_wdata;
  logic ac_crf_axisi_tvalid, ac_crf_axisi_tready, ac_crf_axiso_tvalid, ac_crf_axiso_tready;
  int total = 0, bad = 0;
  int ph = 0, n_in = 0, n_out = 0;
  int pv = 80, pr = 80;
  bit tog = 0;
  int dut_wr = 0, din = 0, tl = 0, j_in = 0, j_tl = 0;
  always #5 clk = ~clk;
  stream_access_control #(.SRC_W(SW), .SRC_H(SH), .SCALE(SC), .PIX_WIDTH(PW),
                          .CRF_DATA_WIDTH(32), .CRF_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .ac_up_tvalid(ac_up_tvalid), .up_ac_tready(up_ac_tready), .ac_up_tdata(ac_up_tdata),
    .ac_up_tuser(ac_up_tuser), .ac_up_tlast(ac_up_tlast),
    .up_ac_tvalid(up_ac_tvalid), .ac_up_tready(ac_up_tready), .up_ac_tdata(up_ac_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .crf_ac_UPSTART(crf_ac_UPSTART), .crf_ac_UPEND(crf_ac_UPEND), .crf_ac_wbusy(crf_ac_wbusy),
    .ac_crf_wrt(ac_crf_wrt), .ac_crf_waddr(ac_crf_waddr), .ac_crf_wdata(ac_crf_wdata),
    .ac_crf_processing(ac_crf_processing),
    .ac_crf_axisi_tvalid(ac_crf_axisi_tvalid), .ac_crf_axisi_tready(ac_crf_axisi_tready),
    .ac_crf_axiso_tvalid(ac_crf_axiso_tvalid), .ac_crf_axiso_tready(ac_crf_axiso_tready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bit run, rep, full, hs_in, hs_out;
    s_axis_tvalid = $urandom_range(99) < pv;
    up_ac_tready = $urandom_range(99) < pr;
    up_ac_tvalid = $urandom_range(99) < pv;
    m_axis_tready = tog ? !m_axis_tready : ($urandom_range(99) < pr);
    s_axis_tdata = PW'($urandom);
    up_ac_tdata = PW'($urandom);
    #1;
    run = ph == 1 && !rst;
    rep = ph == 2 && !rst;
    full = n_in >= NIN;
    chk("s_tready", s_axis_tready, run && up_ac_tready && !full);
    chk("up_tvalid", ac_up_tvalid, run && s_axis_tvalid && !full);
    chk("up_tdata", ac_up_tdata, s_axis_tdata);
    chk("up_tuser", ac_up_tuser, run && n_in == 0);
    chk("up_tlast", ac_up_tlast, run && !full && n_in % SW == SW - 1);
    chk("m_tvalid", m_axis_tvalid, run && up_ac_tvalid);
    chk("core_tready", ac_up_tready, run && m_axis_tready);
    chk("m_tdata", m_axis_tdata, up_ac_tdata);
    chk("m_tuser", m_axis_tuser, run && n_out == 0);
    chk("m_tlast", m_axis_tlast, run && n_out % OW == OW - 1);
    chk("processing", ac_crf_processing, run);
    chk("wrt", ac_crf_wrt, rep);
    chk("waddr", ac_crf_waddr, 0);
    chk("wdata", ac_crf_wdata, rep ? 2 : 0);
    chk("tap_i_valid", ac_crf_axisi_tvalid, s_axis_tvalid);
    chk("tap_i_ready", ac_crf_axisi_tready, run && up_ac_tready && !full);
    chk("tap_o_valid", ac_crf_axiso_tvalid, run && up_ac_tvalid);
    chk("tap_o_ready", ac_crf_axiso_tready, m_axis_tready);
    dut_wr += int'(ac_crf_wrt);
    din += int'(s_axis_tvalid && s_axis_tready);
    tl += int'(m_axis_tvalid && m_axis_tready && m_axis_tlast);
    hs_in = run && s_axis_tvalid && up_ac_tready && !full;
    hs_out = run && up_ac_tvalid && m_axis_tready;
    if (rst) begin
      ph = 0;
      n_in = 0;
      n_out = 0;
    end else
      case (ph)
        0: if (crf_ac_UPSTART && !crf_ac_UPEND) begin ph = 1; n_in = 0; n_out = 0; end
        1: if (!crf_ac_UPSTART) ph = 0;
           else begin
             n_in += int'(hs_in);
             n_out += int'(hs_out);
             if (n_out == NOUT) ph = 2;
           end
        2: if (!crf_ac_wbusy) ph = 3;
        default: if (!crf_ac_UPEND) ph = 0;
      endcase
    @(posedge clk);
    #1;
  endtask
  task automatic start_job();
    crf_ac_UPSTART = 1;
    j_in = din;
    j_tl = tl;
    step();
    chk("proc_on", ac_crf_processing, 1);
  endtask
  task automatic to_report();
    for (int k = 0; k < 4000 && ph != 2; k++) step();
    chk("reach_report", ac_crf_wrt, 1);
  endtask
  task automatic finish_job(input int busy);
    int w0;
    w0 = dut_wr;
    crf_ac_wbusy = busy > 0;
    for (int k = 0; k < busy; k++) step();
    crf_ac_wbusy = 0;
    step();
    chk("wrt_cycles", dut_wr - w0, busy + 1);
    chk("wrt_off", ac_crf_wrt, 0);
    chk("in_beats", din - j_in, NIN);
    chk("tlast_cnt", tl - j_tl, SH * SC);
    crf_ac_UPSTART = 0;
    crf_ac_UPEND = 1;
  endtask
  initial begin
    int w0;
    rst = 1;
    crf_ac_UPSTART = 0;
    crf_ac_UPEND = 0;
    crf_ac_wbusy = 0;
    m_axis_tready = 0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    step();
    start_job();
    to_report();
    finish_job(0);
    step();
    crf_ac_UPSTART = 1;
    for (int k = 0; k < 4; k++) step();
    chk("done_no_restart", ac_crf_processing, 0);
    crf_ac_UPSTART = 0;
    crf_ac_UPEND = 0;
    step();
    start_job();
    chk("restart_sof", ac_up_tuser, 1);
    to_report();
    finish_job(5);
    crf_ac_UPEND = 0;
    step();
    start_job();
    for (int k = 0; k < 300 && n_in < 3; k++) step();
    chk("abort_reach", ac_crf_processing, 1);
    w0 = dut_wr;
    crf_ac_UPSTART = 0;
    step();
    for (int k = 0; k < 3; k++) step();
    chk("abort_idle", ac_crf_processing, 0);
    chk("abort_nowrite", dut_wr - w0, 0);
    start_job();
    chk("abort_sof", ac_up_tuser, 1);
    to_report();
    finish_job(0);
    crf_ac_UPEND = 0;
    step();
    pv = 100;
    tog = 1;
    start_job();
    to_report();
    tog = 0;
    pv = 80;
    finish_job(0);
    crf_ac_UPEND = 0;
    step();
    start_job();
    for (int k = 0; k < 2000 && n_out < 50; k++) step();
    chk("beat50_reach", ac_crf_processing, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_proc", ac_crf_processing, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_m_valid", m_axis_tvalid, 0);
    start_job();
    to_report();
    finish_job(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
